// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor driving a single full-adder cell, LSB first.
// Define SERIAL_ADDER_OVF_EN to build the signed-overflow detector; otherwise overflow reads 0.

module onebit_adder (
    input  logic in_1,
    input  logic in_2,
    input  logic c_in,
    output logic sum,
    output logic c_out
);
    assign sum   = in_1 ^ in_2 ^ c_in;
    assign c_out = (in_1 & in_2) | (c_in & (in_1 ^ in_2));
endmodule

module serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_CNT  = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_sum;
    logic             bit_carry;
    logic             last_bit;
    logic             msb_bit;

    onebit_adder u_bit (
        .in_1  (a_sh[0]),
        .in_2  (b_sh[0]),
        .c_in  (carry),
        .sum   (bit_sum),
        .c_out (bit_carry)
    );

    assign last_bit = (cnt == LAST_CNT);
    assign msb_bit  = (cnt == MSB_CNT);
    assign r_next   = {bit_sum, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            c_out  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                        a_sh  <= in_a;
                        b_sh  <= sub ? ~in_b : in_b;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= bit_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        result <= r_next;
                        c_out  <= bit_carry;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic c_msb_in;

    // Overflow is the carry into the MSB disagreeing with the carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_msb_in <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            if (msb_bit) c_msb_in <= bit_carry;
            if (last_bit) overflow <= c_msb_in ^ bit_carry;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
